// File: rtl/mips_prog_loader.sv
// mips_prog_loader
// Boot-time program loader for the pipe_MIPS32 unified memory.
// Consumes a word stream (start address, word count, payload words), writes
// the payload through a single registered write port, and releases the core
// (core_run) only once the whole image has been committed.
// Build option: define CHECKSUM_EN to require a trailing XOR checksum word
// after the payload. Without it, the load completes on the last data word.
module mips_prog_loader #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 1024
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              start,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              core_run,
  output logic              err
);

`ifdef CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, HADDR, HLEN, DATA, CHK, DONE, ERR} state_t;
`else
  typedef enum logic [2:0] {IDLE, HADDR, HLEN, DATA, DONE, ERR} state_t;
`endif

  // One past the last legal word address, in the widened header-check width.
  localparam logic [ADDR_W+1:0] DEPTH_END = (ADDR_W+2)'(MEM_DEPTH);
  localparam logic [ADDR_W:0]   REM_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

  state_t            state;
  logic [ADDR_W-1:0] ptr;        // next write address (base + index)
  logic [ADDR_W:0]   remaining;  // data words still expected
`ifdef CHECKSUM_EN
  logic [DATA_W-1:0] csum;       // running XOR of accepted data words
`endif

  logic              xfer;
  logic [ADDR_W:0]   hdr_len;
  logic [ADDR_W+1:0] hdr_end;
  logic              hdr_overflow;
  logic              last_word;

  // Handshake and header decode; ptr holds the base while in HLEN.
  always_comb begin
    xfer         = s_valid && s_ready;
    hdr_len      = s_data[ADDR_W:0];
    hdr_end      = {2'b00, ptr} + {1'b0, hdr_len};
    hdr_overflow = (hdr_end > DEPTH_END);
    last_word    = (remaining == REM_ONE);
  end

  // Loader FSM with registered stream, memory and status outputs.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      remaining <= '0;
`ifdef CHECKSUM_EN
      csum      <= '0;
`endif
      s_ready   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      core_run  <= 1'b0;
      err       <= 1'b0;
    end else begin
      // Write enable is a single-cycle pulse per accepted data word.
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= HADDR;
            s_ready  <= 1'b1;
            busy     <= 1'b1;
            core_run <= 1'b0;
            err      <= 1'b0;
`ifdef CHECKSUM_EN
            csum     <= '0;
`endif
          end
        end

        HADDR: begin
          if (xfer) begin
            ptr   <= s_data[ADDR_W-1:0];
            state <= HLEN;
          end
        end

        HLEN: begin
          if (xfer) begin
            remaining <= hdr_len;
            if (hdr_len == '0) begin
`ifdef CHECKSUM_EN
              // Empty image still carries a checksum word (expected 0).
              state <= CHK;
`else
              state   <= DONE;
              s_ready <= 1'b0;
              busy    <= 1'b0;
`endif
            end else if (hdr_overflow) begin
              // Image would run past the end of memory: reject before any write.
              state   <= ERR;
              s_ready <= 1'b0;
              busy    <= 1'b0;
              err     <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
        end

        DATA: begin
          if (xfer) begin
            mem_we    <= 1'b1;
            mem_addr  <= ptr;
            mem_wdata <= s_data;
            ptr       <= ptr + PTR_ONE;
            remaining <= remaining - REM_ONE;
`ifdef CHECKSUM_EN
            csum      <= csum ^ s_data;
`endif
            if (last_word) begin
`ifdef CHECKSUM_EN
              state <= CHK;
`else
              state   <= DONE;
              s_ready <= 1'b0;
              busy    <= 1'b0;
`endif
            end
          end
        end

`ifdef CHECKSUM_EN
        CHK: begin
          if (xfer) begin
            s_ready <= 1'b0;
            busy    <= 1'b0;
            if (s_data == csum) begin
              state <= DONE;
            end else begin
              state <= ERR;
              err   <= 1'b1;
            end
          end
        end
`endif

        DONE: begin
          // core_run rises one edge after entry, i.e. after the final write
          // pulse has been presented to memory.
          if (start) begin
            state    <= HADDR;
            s_ready  <= 1'b1;
            busy     <= 1'b1;
            core_run <= 1'b0;
            err      <= 1'b0;
`ifdef CHECKSUM_EN
            csum     <= '0;
`endif
          end else begin
            core_run <= 1'b1;
          end
        end

        ERR: begin
          if (start) begin
            state    <= HADDR;
            s_ready  <= 1'b1;
            busy     <= 1'b1;
            core_run <= 1'b0;
            err      <= 1'b0;
`ifdef CHECKSUM_EN
            csum     <= '0;
`endif
          end
        end

        default: begin
          state    <= IDLE;
          s_ready  <= 1'b0;
          busy     <= 1'b0;
          core_run <= 1'b0;
          err      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_prog_loader.sv
// Testbench for mips_prog_loader: directed and randomized loads checked
// against an image-level model (expected write list, outcome, checksum).
// Define CHECKSUM_EN for both DUT and bench to exercise the checksum build.
module tb_mips_prog_loader;
  localparam int DEPTH = 1024;

  logic        clk1    = 1'b0;
  logic        rst_n   = 1'b0;
  logic        start   = 1'b0;
  logic        s_valid = 1'b0;
  logic [31:0] s_data  = '0;
  logic        s_ready, mem_we, busy, core_run, err;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] payload[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_wr     = 0;

  always #5 clk1 = ~clk1;

  mips_prog_loader #(.ADDR_W(10), .DATA_W(32), .MEM_DEPTH(DEPTH)) dut (
    .clk1      (clk1),
    .rst_n     (rst_n),
    .start     (start),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .core_run  (core_run),
    .err       (err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, sample 1 time unit after the edge, score any write.
  task automatic step();
    wr_t e;
    @(posedge clk1);
    #1;
    if (mem_we === 1'b1) begin
      n_wr++;
      if (exp_q.size() == 0) begin
        check("stray_write", {54'd0, mem_addr}, 64'hffff);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", {54'd0, mem_addr}, {54'd0, e.addr});
        check("wr_data", {32'd0, mem_wdata}, {32'd0, e.data});
      end
    end
  endtask

  // Idle for gap cycles (optionally pulsing start), then present one word
  // until it is accepted or the budget runs out.
  task automatic send(input logic [31:0] d, input int gap, input bit poke);
    bit rdy;
    int n;
    s_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      start = poke && (g == 0);
      step();
      start = 1'b0;
    end
    s_valid = 1'b1;
    s_data  = d;
    n = 0;
    do begin
      rdy = s_ready;
      step();
      n++;
    end while (!rdy && n < 20);
    check("handshake", {63'd0, rdy}, 64'd1);
    s_valid = 1'b0;
    s_data  = $urandom;
  endtask

  task automatic fill_random(input int n);
    payload.delete();
    repeat (n) payload.push_back($urandom);
  endtask

  // Full load: start, header, payload (from queue), optional checksum word.
  task automatic run_load(input string tag, input logic [31:0] hbase, input logic [31:0] hlen,
                          input int gmin, input int gmax, input bit poke,
                          input bit chk_auto, input logic [31:0] chk_word);
    int          b, l, w0;
    bit          hdr_err, exp_err;
    logic [31:0] x;
    wr_t         e;
    b       = int'(hbase & 32'h3ff);
    l       = int'(hlen & 32'h7ff);
    hdr_err = (l != 0) && (b + l > DEPTH);
    exp_err = hdr_err;
    start = 1'b1;
    step();
    start = 1'b0;
    w0 = n_wr;
    check({tag, " busy_after_start"}, {63'd0, busy}, 64'd1);
    check({tag, " ready_after_start"}, {63'd0, s_ready}, 64'd1);
    check({tag, " err_cleared"}, {63'd0, err}, 64'd0);
    check({tag, " run_cleared"}, {63'd0, core_run}, 64'd0);
    send(hbase, 0, 1'b0);
    send(hlen, $urandom_range(gmax, gmin), 1'b0);
    x = '0;
    if (!hdr_err) begin
      for (int i = 0; i < l; i++) begin
        x ^= payload[i];
        e.addr = 10'(b + i);
        e.data = payload[i];
        exp_q.push_back(e);
      end
      for (int i = 0; i < l; i++) begin
        int g;
        g = $urandom_range(gmax, gmin);
        if (poke && i == l / 2 && g == 0) g = 1;
        send(payload[i], g, poke && (i == l / 2));
      end
`ifdef CHECKSUM_EN
      if (chk_auto) begin
        send(x, 0, 1'b0);
      end else begin
        exp_err = (chk_word != x);
        send(chk_word, 0, 1'b0);
      end
`endif
    end
    check({tag, " run_before_release"}, {63'd0, core_run}, 64'd0);
    step();
    check({tag, " core_run"}, {63'd0, core_run}, {63'd0, !exp_err});
    check({tag, " err"}, {63'd0, err}, {63'd0, exp_err});
    check({tag, " busy_end"}, {63'd0, busy}, 64'd0);
    check({tag, " ready_end"}, {63'd0, s_ready}, 64'd0);
    check({tag, " writes_pending"}, 64'(exp_q.size()), 64'd0);
    check({tag, " write_count"}, 64'(n_wr - w0), hdr_err ? 64'd0 : 64'(l));
    exp_q.delete();
    payload.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time budget exhausted");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, l, w0;
    wr_t e;

    // Reset values.
    rst_n = 1'b0;
    step();
    step();
    check("rst s_ready", {63'd0, s_ready}, 64'd0);
    check("rst mem_we", {63'd0, mem_we}, 64'd0);
    check("rst mem_addr", {54'd0, mem_addr}, 64'd0);
    check("rst mem_wdata", {32'd0, mem_wdata}, 64'd0);
    check("rst busy", {63'd0, busy}, 64'd0);
    check("rst core_run", {63'd0, core_run}, 64'd0);
    check("rst err", {63'd0, err}, 64'd0);
    rst_n = 1'b1;
    step();

    // Stream words in IDLE are not accepted.
    s_valid = 1'b1;
    s_data  = $urandom;
    step();
    step();
    check("idle s_ready", {63'd0, s_ready}, 64'd0);
    check("idle busy", {63'd0, busy}, 64'd0);
    s_valid = 1'b0;

    // Reference program at address 0.
    payload = '{32'h28010078, 32'h0c631800, 32'h20220000, 32'h0c631800,
                32'h2842002d, 32'h0c631800, 32'h24220001, 32'hfc000000};
    run_load("t1_prog", 32'd0, 32'd8, 0, 0, 1'b0, 1'b1, 32'd0);

    // Empty image.
    run_load("t2_empty", 32'd120, 32'd0, 0, 0, 1'b0, 1'b1, 32'd0);

    // DONE ignores stream traffic and keeps the core released.
    s_valid = 1'b1;
    s_data  = $urandom;
    repeat (3) step();
    check("done_hold core_run", {63'd0, core_run}, 64'd1);
    check("done_hold s_ready", {63'd0, s_ready}, 64'd0);
    s_valid = 1'b0;

    // Overflowing header, then recovery with a valid load.
    run_load("t3_overflow", 32'd1020, 32'd8, 0, 0, 1'b0, 1'b1, 32'd0);
    fill_random(5);
    run_load("t3_recover", 32'd100, 32'd5, 0, 1, 1'b0, 1'b1, 32'd0);

    // Valid toggling 1,0,0,1 between data words.
    fill_random(6);
    run_load("t4_gaps", 32'd300, 32'd6, 2, 2, 1'b0, 1'b1, 32'd0);

    // End-of-memory boundaries and header field masking.
    fill_random(8);
    run_load("edge_exact", 32'd1016, 32'd8, 0, 1, 1'b0, 1'b1, 32'd0);
    run_load("edge_over", 32'd1017, 32'd8, 0, 0, 1'b0, 1'b1, 32'd0);
    fill_random(1);
    run_load("edge_last", 32'd1023, 32'd1, 0, 0, 1'b0, 1'b1, 32'd0);
    fill_random(4);
    run_load("mask_fields", 32'hABCD_0010, 32'hFFFF_F804, 0, 1, 1'b0, 1'b1, 32'd0);
    run_load("len_1024_over", 32'd1, 32'h400, 0, 0, 1'b0, 1'b1, 32'd0);
    run_load("len_bit11_zero", 32'd5, 32'h800, 0, 0, 1'b0, 1'b1, 32'd0);

    // Randomized loads, some with an ignored start pulse mid-payload.
    for (int k = 0; k < 5; k++) begin
      l = $urandom_range(24, 1);
      b = $urandom_range(1023, 0);
      if (b + l > DEPTH) b = DEPTH - l;
      fill_random(l);
      run_load("rand_load", 32'(b), 32'(l), 0, 3, (k % 2) == 1, 1'b1, 32'd0);
    end

    // Reset after the third data word: immediate clear, no fourth write.
    fill_random(8);
    start = 1'b1;
    step();
    start = 1'b0;
    w0 = n_wr;
    send(32'd0, 0, 1'b0);
    send(32'd8, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      e.addr = 10'(i);
      e.data = payload[i];
      exp_q.push_back(e);
      send(payload[i], 0, 1'b0);
    end
    check("t5 third_write", {63'd0, mem_we}, 64'd1);
    s_valid = 1'b1;
    s_data  = payload[3];
    rst_n   = 1'b0;
    #1;
    check("t5 async mem_we", {63'd0, mem_we}, 64'd0);
    check("t5 async mem_addr", {54'd0, mem_addr}, 64'd0);
    check("t5 async mem_wdata", {32'd0, mem_wdata}, 64'd0);
    check("t5 async busy", {63'd0, busy}, 64'd0);
    check("t5 async s_ready", {63'd0, s_ready}, 64'd0);
    check("t5 async core_run", {63'd0, core_run}, 64'd0);
    check("t5 async err", {63'd0, err}, 64'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    check("t5 idle s_ready", {63'd0, s_ready}, 64'd0);
    check("t5 idle busy", {63'd0, busy}, 64'd0);
    check("t5 write_count", 64'(n_wr - w0), 64'd3);
    s_valid = 1'b0;
    payload.delete();
    exp_q.delete();

    // Fresh load after the aborted one.
    fill_random(3);
    run_load("post_reset", 32'd40, 32'd3, 0, 1, 1'b0, 1'b1, 32'd0);

`ifdef CHECKSUM_EN
    // Checksum mismatch then match.
    payload = '{32'd5, 32'd3};
    run_load("t6_bad_sum", 32'd0, 32'd2, 0, 0, 1'b0, 1'b0, 32'd7);
    payload = '{32'd5, 32'd3};
    run_load("t6_good_sum", 32'd0, 32'd2, 0, 0, 1'b0, 1'b0, 32'd6);
    run_load("t6_empty_bad", 32'd9, 32'd0, 0, 0, 1'b0, 1'b0, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
